rr_arbiter4: RTL

- Four-requester round-robin arbiter built around 4-to-2 priority encoding with a rotating priority pointer.
- Shares one resource between four requesters: grants one at a time, holds the grant while the owner keeps requesting, and forces release after a programmable hold limit.
- Drives a one-hot grant plus the encoded owner index and a valid flag for downstream muxing.

---
 rtl/rr_arbiter4.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a rotating priority pointer and a
// programmable hold limit. Outputs are registered; a grant is held while its
// owner keeps requesting, and is forcibly handed off after MAX_HOLD cycles if
// another requester is waiting.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // Last hold_cnt value before the limit trips; unused when the limit is off.
  localparam bit         HoldEn   = (MAX_HOLD != 0);
  localparam logic [7:0] HoldLast = HoldEn ? 8'(MAX_HOLD - 1) : 8'd0;

  state_e     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_idx;
  logic       r_valid;
  logic [1:0] r_ptr;
  logic [7:0] r_hold_cnt;

  logic [3:0] w_others;
  logic       w_own_req;
  logic       w_limit;
  logic       w_release;
  logic [3:0] w_scan_vec;
  logic [1:0] w_scan_start;
  logic       w_win_found;
  logic [1:0] w_win_idx;

  // Release decision for the current owner and selection of the scan inputs.
  always_comb begin
    w_others     = req & ~r_gnt;
    w_own_req    = req[r_idx];
    w_limit      = HoldEn && (r_hold_cnt == HoldLast);
    w_release    = (r_state == StGrant) && (!w_own_req || (w_limit && (|w_others)));
    // In IDLE scan the raw request from ptr; on release skip the old owner.
    w_scan_vec   = (r_state == StIdle) ? req : w_others;
    w_scan_start = (r_state == StIdle) ? r_ptr : 2'(r_idx + 2'd1);
  end

  // Rotating priority scan: first set bit at offset 0..3 from the start wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = w_scan_start;
    // Walk from the farthest offset down so the nearest set bit is kept.
    for (int i = 3; i >= 0; i--) begin
      if (w_scan_vec[w_scan_start + 2'(i)]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan_start + 2'(i);
      end
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gnt      <= 4'b0000;
      r_idx      <= 2'd0;
      r_valid    <= 1'b0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= 8'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_win_found) begin
            r_state    <= StGrant;
            r_gnt      <= 4'(4'b0001 << w_win_idx);
            r_idx      <= w_win_idx;
            r_valid    <= 1'b1;
            r_hold_cnt <= 8'd0;
          end
        end
        StGrant: begin
          if (w_release) begin
            r_ptr      <= 2'(r_idx + 2'd1);
            r_hold_cnt <= 8'd0;
            if (w_win_found) begin
              // Direct handoff, no idle cycle between owners.
              r_gnt <= 4'(4'b0001 << w_win_idx);
              r_idx <= w_win_idx;
            end else begin
              r_state <= StIdle;
              r_gnt   <= 4'b0000;
              r_idx   <= 2'd0;
              r_valid <= 1'b0;
            end
          end else if (w_limit) begin
            // Sole requester at the limit keeps the grant; restart the count.
            r_hold_cnt <= 8'd0;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;

endmodule
